// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: memory access size encodings.
package mips_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_t;

endpackage

// File: rtl/dm_load_ext.sv
// Load data path: picks the addressed byte/half lane out of a memory word and extends it.
module dm_load_ext
  import mips_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  mem_size_t   size,
  input  logic        uext,
  output logic [31:0] rdata
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[{lane, 3'b000} +: 8];
    sel_half = lane[1] ? word[31:16] : word[15:0];
    rdata    = '0;
    unique case (size)
      SZ_BYTE: rdata = {{24{~uext & sel_byte[7]}}, sel_byte};
      SZ_HALF: rdata = {{16{~uext & sel_half[15]}}, sel_half};
      SZ_WORD: rdata = word;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dm_byte_lane.sv
// MEM-stage data memory with byte/half/word stores and loads, AdEL/AdES detection and a store log.
module dm_byte_lane
  import mips_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          LOG_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  size,
  input  logic        uext,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  logic [31:0]            mem [DEPTH_WORDS];
  // Reset clears a per-word valid bit instead of sweeping the array.
  logic [DEPTH_WORDS-1:0] vld;

  mem_size_t   sz;
  logic [32:0] diff;
  logic [31:0] off;
  logic [AW-1:0] widx;
  logic        below_base;
  logic        out_of_range;
  logic        misaligned;
  logic        addr_err;
  logic [31:0] cur_word;
  logic [31:0] ext_data;
  logic [3:0]  be;
  logic [31:0] wd_rep;
  logic [31:0] merged;
  logic        commit;

  assign sz = mem_size_t'(size);

  // The 33rd bit of the subtract is the borrow, i.e. addr < BASE_ADDR.
  assign diff         = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign off          = diff[31:0];
  assign below_base   = diff[32];
  assign widx         = off[AW+1:2];
  assign out_of_range = below_base | ({1'b0, off} >= SPAN);

  always_comb begin
    misaligned = 1'b0;
    unique case (sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign addr_err = misaligned | out_of_range;
  assign adel     = re & addr_err;
  assign ades     = we & addr_err;

  assign cur_word = vld[widx] ? mem[widx] : 32'h0;

  dm_load_ext u_load_ext (
    .word  (cur_word),
    .lane  (off[1:0]),
    .size  (sz),
    .uext  (uext),
    .rdata (ext_data)
  );

  assign rdata = (re & ~adel) ? ext_data : 32'h0;

  always_comb begin
    be     = 4'b0000;
    wd_rep = wdata;
    unique case (sz)
      SZ_BYTE: begin
        be     = 4'b0001 << off[1:0];
        wd_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        be     = 4'b1111;
        wd_rep = wdata;
      end
      default: begin
        be     = 4'b0000;
        wd_rep = wdata;
      end
    endcase
  end

  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wd_rep[8*i +: 8];
    end
  end

  assign commit = we & ~reset & ~ades;

  always_ff @(posedge clk) begin
    if (commit) mem[widx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else if (commit) begin
      vld[widx] <= 1'b1;
    end
  end

  generate
    if (LOG_EN) begin : g_log
      always_ff @(posedge clk) begin
        if (commit) $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
      end
    end
  endgenerate

endmodule
